// File: rtl/riscv_mux_pkg.sv
// Shared helpers for the result-bus multiplexors: channel-index width and
// one-hot to binary index conversion.
package riscv_mux_pkg;

   localparam int MAX_CH = 64;

   // Index width that never collapses to zero bits for a single channel.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int onehot_to_idx(input logic [MAX_CH-1:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (oh[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant over NUM_CH requests. Round-robin starting after rr_ptr by default;
// define ARB_MULTIPLEXOR_FIXED_PRIO_EN for fixed priority (channel 0 highest).
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] in_valid,
   input  logic [CH_W-1:0]   rr_ptr,
   output logic [NUM_CH-1:0] grant
);

   logic found;

`ifdef ARB_MULTIPLEXOR_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^rr_ptr;

   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && in_valid[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`else
   int idx;

   // Search rr_ptr+1, rr_ptr+2, ... wrapping, so the last winner goes to the back.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_CH;
         if (!found && in_valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/arb_multiplexor.sv
// N-channel valid/ready multiplexor with arbitration and a single-entry output register.
// Build option: ARB_MULTIPLEXOR_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module arb_multiplexor
   import riscv_mux_pkg::*;
#(
   parameter  int MUX_WIDTH = 32,
   parameter  int NUM_CH    = 4,
   localparam int CH_W      = clog2_min1(NUM_CH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CH-1:0]           in_valid,
   input  logic [NUM_CH*MUX_WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]           in_ready,
   output logic                        out_valid,
   output logic [MUX_WIDTH-1:0]        out_data,
   output logic [CH_W-1:0]             out_ch,
   input  logic                        out_ready
);

   logic [NUM_CH-1:0]    grant;
   logic [CH_W-1:0]      rr_ptr_p1;
   logic [CH_W-1:0]      grant_idx;
   logic [MUX_WIDTH-1:0] sel_data;
   logic                 load;
   logic                 xfer;
   logic                 vld_p1;
   logic [MUX_WIDTH-1:0] data_p1;
   logic [CH_W-1:0]      ch_p1;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_arb (
      .in_valid (in_valid),
      .rr_ptr   (rr_ptr_p1),
      .grant    (grant)
   );

   // in_ready is held low during reset so nothing is accepted into a clearing register.
   assign load      = !vld_p1 | out_ready;
   assign in_ready  = grant & {NUM_CH{load & rst_n}};
   assign xfer      = |in_ready;
   assign grant_idx = CH_W'(onehot_to_idx(MAX_CH'(grant)));

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) sel_data = in_data[i*MUX_WIDTH +: MUX_WIDTH];
      end
   end

`ifdef ARB_MULTIPLEXOR_FIXED_PRIO_EN
   assign rr_ptr_p1 = CH_W'(NUM_CH - 1);
`else
   if (NUM_CH == 1) begin : g_ptr_const
      assign rr_ptr_p1 = '0;
   end else begin : g_ptr_reg
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rr_ptr_p1 <= CH_W'(NUM_CH - 1);
         end else if (xfer) begin
            rr_ptr_p1 <= grant_idx;
         end
      end
   end
`endif

   // ---- stage p1: output register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         ch_p1   <= '0;
      end else if (xfer) begin
         vld_p1  <= 1'b1;
         data_p1 <= sel_data;
         ch_p1   <= grant_idx;
      end else if (out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign out_ch    = ch_p1;

endmodule

// File: tb/tb_arb_multiplexor.sv
// Scoreboard bench for arb_multiplexor (MUX_WIDTH=5, NUM_CH=4); expectations follow
// ARB_MULTIPLEXOR_FIXED_PRIO_EN when defined.
module tb_arb_multiplexor;

   localparam int W = 5;
   localparam int N = 4;
`ifdef ARB_MULTIPLEXOR_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [1:0]     out_ch;
   logic           out_ready;

   typedef struct packed {
      logic [W-1:0] d;
      logic [1:0]   ch;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;
   int   a_ch;
   int   b_ch;

   arb_multiplexor #(
      .MUX_WIDTH (W),
      .NUM_CH    (N)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int d, input int ch);
      q.push_back('{d: W'(d), ch: 2'(ch)});
   endtask

   task automatic data_seq();
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(i + 1);
   endtask

   // Monitor: every word the sink takes must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_unexpected: got ch %0d data %0h expected no word", out_ch, out_data);
         end else begin
            e = q.pop_front();
            check("sb_data", 32'(out_data), 32'(e.d));
            check("sb_ch", 32'(out_ch), 32'(e.ch));
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = '1;
      in_data   = '0;
      out_ready = 1'b1;
      data_seq();

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_ch", 32'(out_ch), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);

      // Single channel
      @(posedge clk); #1;
      rst_n    = 1'b1;
      in_valid = 4'b0100;
      in_data[2*W +: W] = 5'h15;
      @(negedge clk);
      check("single_in_ready", 32'(in_ready), 32'(4'b0100));
      push(5'h15, 2);
      @(posedge clk); #1;
      in_valid = '0;
      data_seq();
      repeat (2) @(posedge clk);

      // Round-robin from a fresh reset
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      in_valid = '1;
      for (int k = 0; k < 5; k++) begin
         push(FIXED ? 1 : (k % N) + 1, FIXED ? 0 : k % N);
         @(posedge clk);
      end
      #1 in_valid = '0;
      @(posedge clk); #1;

      // Backpressure
      a_ch      = FIXED ? 0 : 1;
      b_ch      = FIXED ? 0 : 2;
      out_ready = 1'b0;
      in_valid  = '1;
      push(a_ch + 1, a_ch);
      @(posedge clk);
      repeat (3) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_out_data", 32'(out_data), 32'(a_ch + 1));
         check("stall_out_ch", 32'(out_ch), 32'(a_ch));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      push(b_ch + 1, b_ch);
      @(negedge clk);
      check("resume_in_ready", 32'(in_ready), 32'(1 << b_ch));
      @(posedge clk); #1;
      in_valid = '0;
      @(posedge clk); #1;

      // Wrap and skip
      in_valid = 4'b1000;
      push(4, 3);
      @(posedge clk); #1;
      in_valid = 4'b1010;
      push(2, 1);
      @(negedge clk);
      check("skip_in_ready", 32'(in_ready), 32'(4'b0010));
      @(posedge clk); #1;
      push(FIXED ? 2 : 4, FIXED ? 1 : 3);
      @(posedge clk); #1;
      in_valid = '0;
      @(posedge clk); #1;

      // Mid-stream reset discards the held word
      out_ready = 1'b0;
      in_valid  = '1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_pre_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("midrst_first_grant", 32'(in_ready), 32'(4'b0001));
      push(1, 0);
      @(posedge clk); #1;
      in_valid = '0;
      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
